digit_scan_counter: RTL and testbench
=====================================

DIGIT_SCAN_COUNTER -- requirements
Module: digit_scan_counter

Interface
REQ-001 Parameter DIGIT_W, default 2, bits per digit.
REQ-002 Parameter DIGITS, default 4, digits per value; WIDTH = DIGIT_W*DIGITS (default 8).
REQ-003 Parameter DIGIT_CYCLES, default 4, cycles each digit is held during scan (>=1).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 on  input  2  mode select: 0 off, 1 scan, 2 count, 3 load.
REQ-007 start  input  1  run qualifier for count and scan.
REQ-008 x  input  WIDTH  load value.
REQ-009 s  output  WIDTH  stored value.
REQ-010 digit  output  DIGIT_W  currently scanned digit.
REQ-011 digit_idx  output  clog2(DIGITS) (min 1)  index of scanned digit.
REQ-012 digit_valid  output  1  high while digit/digit_idx are meaningful.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse at scan completion or count reaching zero.

Function
REQ-015 States IDLE, COUNT, LOAD, SCAN; all outputs registered.
REQ-016 IDLE: on=2 & start -> COUNT; on=3 -> LOAD; on=1 & start -> SCAN; otherwise stay IDLE; s unchanged on the entry edge.
REQ-017 COUNT: each edge with on=2 & start: s <= s-1; any edge without both: -> IDLE, s unchanged.
REQ-018 LOAD: s <= x on the edge leaving LOAD (exactly one cycle), then -> IDLE; held on=3 re-enters LOAD from IDLE (load every second cycle).
REQ-019 SCAN: digit i = s[i*DIGIT_W +: DIGIT_W], LSD first, i from 0 to DIGITS-1, each held DIGIT_CYCLES cycles; digit_valid high the whole time.
REQ-020 SCAN: on/start ignored until complete; after DIGITS*DIGIT_CYCLES cycles -> IDLE with done pulsed on the exit cycle.
REQ-021 s is frozen during SCAN (digits consistent).
REQ-022 digit_valid low, digit and digit_idx 0 outside SCAN.
REQ-023 Zero boundary in COUNT: governed by REQ-027/028; done pulses on the cycle s becomes 0 via decrement.

Reset
REQ-024 rst high at an edge: state IDLE, s=0, digit=0, digit_idx=0, digit_valid=0, busy=0, done=0; overrides any mode mid-operation, including mid-scan.
REQ-025 First transition evaluated on the first edge after rst deasserts.

Configuration
REQ-026 Macro CNT_WRAP_EN selects zero behaviour in COUNT.
REQ-027 With CNT_WRAP_EN: decrement of s=0 gives all-ones, stays in COUNT, no done.
REQ-028 Without CNT_WRAP_EN: s saturates at 0; on reaching 0 -> IDLE with done pulse; a decrement attempted at s=0 exits to IDLE with no change.

Structure
REQ-029 Shared package dsc_pkg holds state enum (IDLE, COUNT, LOAD, SCAN) and mode constants MODE_OFF=0, MODE_SCAN=1, MODE_COUNT=2, MODE_LOAD=3.
REQ-030 One sub-module dsc_scan_timer: per-digit cycle counter and digit index, with start/finish signals.

Verification
REQ-031 Reset: rst high 2 cycles during SCAN -> all outputs 0, busy=0 on next edge.
REQ-032 Load: on=3, x=8'd64 for 1 cycle then on=0 -> s=64, busy low after 1 cycle; on=3 held 8 cycles -> 4 loads.
REQ-033 Count: s=64, on=2, start=1 for 6 cycles -> s=59 (entry + 5 decrements), then IDLE when start drops.
REQ-034 Scan: s=8'hE4 (2'b11,10,01,00), on=1, start=1 -> digit 0,1,2,3 each 4 cycles, idx 0..3, done on cycle 16, s unchanged.
REQ-035 Zero: s=1, count mode -> s=0 with done pulse and IDLE (without CNT_WRAP_EN); with CNT_WRAP_EN s goes 1,0,255, no done.
REQ-036 Parameters DIGIT_W=4, DIGITS=3, DIGIT_CYCLES=1: s=12'h5A3 scans 3,A,5 on consecutive cycles.

Source files
------------

// File: rtl/dsc_pkg.sv
// Shared types and constants for the digit scan counter.
package dsc_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LOAD  = 2'd2,
    SCAN  = 2'd3
  } state_t;

  // Mode select encodings on the 'on' input
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_SCAN  = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;
  localparam logic [1:0] MODE_LOAD  = 2'd3;

  // Index width for n items, never below one bit
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dsc_scan_timer.sv
// Scan pacing: holds each digit DIGIT_CYCLES cycles and walks the digit index.
module dsc_scan_timer
  import dsc_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned DIGIT_CYCLES = 4,
  localparam int unsigned IDX_W       = min1_clog2(DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] idx,
  output logic             advance_c,
  output logic             finish_c
);

  localparam int unsigned CYC_W = min1_clog2(DIGIT_CYCLES);

  logic             active;
  logic [CYC_W-1:0] cyc;

  // Last cycle of the current digit, and last cycle of the whole scan
  assign advance_c = active && (cyc == CYC_W'(DIGIT_CYCLES - 1));
  assign finish_c  = advance_c && (idx == IDX_W'(DIGITS - 1));

  // Per-digit cycle counter and digit index; index returns to 0 when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cyc    <= '0;
      idx    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cyc    <= '0;
      idx    <= '0;
    end else if (finish_c) begin
      active <= 1'b0;
      cyc    <= '0;
      idx    <= '0;
    end else if (advance_c) begin
      cyc <= '0;
      idx <= idx + IDX_W'(1);
    end else if (active) begin
      cyc <= cyc + CYC_W'(1);
    end
  end

endmodule

// File: rtl/digit_scan_counter.sv
// Loadable down-counter with a digit-by-digit scan-out of its stored value.
// Optional macro CNT_WRAP_EN: decrementing zero wraps to all-ones instead of
// saturating and exiting.
module digit_scan_counter
  import dsc_pkg::*;
#(
  parameter int unsigned DIGIT_W      = 2,
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned DIGIT_CYCLES = 4,
  localparam int unsigned WIDTH       = DIGIT_W * DIGITS,
  localparam int unsigned IDX_W       = min1_clog2(DIGITS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         on,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  output logic [WIDTH-1:0]   s,
  output logic [DIGIT_W-1:0] digit,
  output logic [IDX_W-1:0]   digit_idx,
  output logic               digit_valid,
  output logic               busy,
  output logic               done
);

  state_t               state, state_n;
  logic [WIDTH-1:0]     s_n;
  logic [DIGIT_W-1:0]   digit_n;
  logic                 valid_n;
  logic                 done_n;
  logic                 scan_go_c;
  logic                 advance_c;
  logic                 finish_c;

  function automatic logic [DIGIT_W-1:0] digit_at(input logic [WIDTH-1:0] v,
                                                  input int unsigned i);
    return v[i*DIGIT_W +: DIGIT_W];
  endfunction

  dsc_scan_timer #(
    .DIGITS       (DIGITS),
    .DIGIT_CYCLES (DIGIT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (scan_go_c),
    .idx       (digit_idx),
    .advance_c (advance_c),
    .finish_c  (finish_c)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s           <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      s           <= s_n;
      digit       <= digit_n;
      digit_valid <= valid_n;
      busy        <= (state_n != IDLE);
      done        <= done_n;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_n   = state;
    s_n       = s;
    digit_n   = '0;
    valid_n   = 1'b0;
    done_n    = 1'b0;
    scan_go_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (on == MODE_COUNT && start) begin
          state_n = COUNT;
        end else if (on == MODE_LOAD) begin
          state_n = LOAD;
        end else if (on == MODE_SCAN && start) begin
          state_n   = SCAN;
          scan_go_c = 1'b1;
          valid_n   = 1'b1;
          digit_n   = digit_at(s, 0);
        end
      end
      COUNT: begin
        if (on == MODE_COUNT && start) begin
`ifdef CNT_WRAP_EN
          s_n = s - WIDTH'(1);
`else
          if (s == '0) begin
            state_n = IDLE;
          end else begin
            s_n = s - WIDTH'(1);
            if (s == WIDTH'(1)) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
`endif
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        s_n     = x;
        state_n = IDLE;
      end
      SCAN: begin
        valid_n = 1'b1;
        digit_n = digit;
        if (finish_c) begin
          state_n = IDLE;
          valid_n = 1'b0;
          digit_n = '0;
          done_n  = 1'b1;
        end else if (advance_c) begin
          digit_n = digit_at(s, int'(digit_idx) + 1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_digit_scan_counter.sv
// Self-checking bench for digit_scan_counter (default and 4x3x1 configurations).
module tb_digit_scan_counter;

  localparam int unsigned DW = 2;
  localparam int unsigned ND = 4;
  localparam int unsigned DC = 4;
  localparam int unsigned W  = DW * ND;
`ifdef CNT_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, digit_valid, busy, done;
  logic [1:0]    on, digit_idx;
  logic [W-1:0]  x, s;
  logic [DW-1:0] digit;

  logic        rst2, start2, valid2, busy2, done2;
  logic [1:0]  on2, idx2;
  logic [11:0] x2, s2;
  logic [3:0]  digit2;

  digit_scan_counter dut (
    .clk(clk), .rst(rst), .on(on), .start(start), .x(x), .s(s), .digit(digit),
    .digit_idx(digit_idx), .digit_valid(digit_valid), .busy(busy), .done(done)
  );

  digit_scan_counter #(.DIGIT_W(4), .DIGITS(3), .DIGIT_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst2), .on(on2), .start(start2), .x(x2), .s(s2), .digit(digit2),
    .digit_idx(idx2), .digit_valid(valid2), .busy(busy2), .done(done2)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode, stored value, elapsed scan cycles, done pulse
  localparam int M_IDLE = 0, M_COUNT = 1, M_LOAD = 2, M_SCAN = 3;
  int           m_mode = M_IDLE;
  logic [W-1:0] m_s = '0;
  int           m_t = 0;
  bit           m_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input logic [1:0] o, input bit st, input logic [W-1:0] xi);
    if (r) begin
      m_mode = M_IDLE; m_s = '0; m_t = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (o == 2'd2 && st) m_mode = M_COUNT;
          else if (o == 2'd3) m_mode = M_LOAD;
          else if (o == 2'd1 && st) begin m_mode = M_SCAN; m_t = 0; end
        end
        M_COUNT: begin
          if (o == 2'd2 && st) begin
            if (m_s == 0) begin
              if (WRAP) m_s = {W{1'b1}};
              else m_mode = M_IDLE;
            end else begin
              m_s = m_s - 1'b1;
              if (m_s == 0 && !WRAP) begin m_mode = M_IDLE; m_done = 1'b1; end
            end
          end else m_mode = M_IDLE;
        end
        M_LOAD: begin m_s = xi; m_mode = M_IDLE; end
        default: begin
          m_t++;
          if (m_t == ND * DC) begin m_mode = M_IDLE; m_done = 1'b1; end
        end
      endcase
    end
  endtask

  task automatic check_all();
    bit scanning;
    int ei;
    logic [W-1:0] sh;
    scanning = (m_mode == M_SCAN);
    ei = scanning ? m_t / DC : 0;
    sh = m_s >> (ei * DW);
    chk("s", 32'(s), 32'(m_s));
    chk("digit", 32'(digit), scanning ? 32'(sh[DW-1:0]) : 32'd0);
    chk("digit_idx", 32'(digit_idx), 32'(ei));
    chk("digit_valid", 32'(digit_valid), 32'(scanning));
    chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic tick(input bit r, input logic [1:0] o, input bit st, input logic [W-1:0] xi);
    rst = r; on = o; start = st; x = xi;
    @(posedge clk);
    model(r, o, st, xi);
    #1;
    check_all();
  endtask

  task automatic tick2(input bit r, input logic [1:0] o, input bit st, input logic [11:0] xi);
    rst2 = r; on2 = o; start2 = st; x2 = xi;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; on = 2'd0; start = 1'b0; x = '0;
    rst2 = 1'b1; on2 = 2'd0; start2 = 1'b0; x2 = '0;

    // Reset state
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("rst_s", 32'(s), 0);
    chk("rst_busy", 32'(busy), 0);

    // Reset in the middle of a scan
    tick(0, 3, 0, 8'hB7);
    tick(0, 0, 0, 8'hB7);
    tick(0, 1, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 2, 1, 0);
    tick(1, 1, 1, 0);
    tick(1, 1, 1, 0);
    chk("midscan_rst_valid", 32'(digit_valid), 0);
    chk("midscan_rst_busy", 32'(busy), 0);
    chk("midscan_rst_s", 32'(s), 0);

    // Single load, then repeated loads with on=3 held
    tick(0, 3, 0, 8'd64);
    tick(0, 0, 0, 8'd64);
    chk("load64", 32'(s), 64);
    chk("load_busy", 32'(busy), 0);
    for (int i = 0; i < 8; i++) tick(0, 3, 0, 8'(i + 1));
    chk("held_load", 32'(s), 8);

    // Count down from 64 for six cycles, then drop start
    tick(0, 3, 0, 8'd64);
    tick(0, 0, 0, 8'd64);
    for (int i = 0; i < 6; i++) tick(0, 2, 1, 0);
    chk("count59", 32'(s), 59);
    chk("count_busy", 32'(busy), 1);
    tick(0, 2, 0, 0);
    chk("count_exit_busy", 32'(busy), 0);
    chk("count_exit_s", 32'(s), 59);

    // Scan of 8'hE4 with noise on on/start while scanning
    tick(0, 3, 0, 8'hE4);
    tick(0, 0, 0, 8'hE4);
    tick(0, 1, 1, 0);
    for (int i = 1; i <= 16; i++) begin
      tick(0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
      if (i < 16) chk("scan_digit_seq", 32'(digit), 32'(i / 4));
    end
    chk("scan_done", 32'(done), 1);
    chk("scan_s_kept", 32'(s), 32'hE4);
    tick(0, 0, 0, 0);
    chk("scan_done_pulse", 32'(done), 0);

    // Zero boundary in count mode
    tick(0, 3, 0, 8'd1);
    tick(0, 0, 0, 8'd1);
    tick(0, 2, 1, 0);
    tick(0, 2, 1, 0);
    chk("zero_s", 32'(s), 0);
    chk("zero_done", 32'(done), WRAP ? 0 : 1);
    tick(0, 2, 1, 0);
    chk("zero_next_s", 32'(s), WRAP ? 255 : 0);
    chk("zero_next_done", 32'(done), 0);
    tick(0, 0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      tick(1'($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), 8'($urandom));
    end

    // Alternate geometry: 4-bit digits, 3 digits, 1 cycle each
    tick2(1, 0, 0, 0);
    tick2(0, 3, 0, 12'h5A3);
    tick2(0, 0, 0, 12'h5A3);
    chk("p2_load", 32'(s2), 32'h5A3);
    tick2(0, 1, 1, 0);
    chk("p2_d0", 32'(digit2), 3);
    chk("p2_i0", 32'(idx2), 0);
    chk("p2_v0", 32'(valid2), 1);
    tick2(0, 0, 0, 0);
    chk("p2_d1", 32'(digit2), 32'hA);
    chk("p2_i1", 32'(idx2), 1);
    tick2(0, 0, 0, 0);
    chk("p2_d2", 32'(digit2), 5);
    chk("p2_i2", 32'(idx2), 2);
    tick2(0, 0, 0, 0);
    chk("p2_done", 32'(done2), 1);
    chk("p2_valid_off", 32'(valid2), 0);
    chk("p2_busy_off", 32'(busy2), 0);
    chk("p2_s_kept", 32'(s2), 32'h5A3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
